// File: rtl/axil_master_v2.sv
// axil_master_v2: single-outstanding AXI4-Lite master driven by a valid/ready command port.
// One command becomes one AXI-Lite read or write; results return with a one-cycle done_o pulse.
module axil_master_v2 #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 256,
    localparam int STRB_W = DATA_W / 8
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_we,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    input  logic [STRB_W-1:0] cmd_wstrb,

    output logic              done_o,
    output logic [DATA_W-1:0] rdata_o,
    output logic [1:0]        resp_o,
    output logic              err_o,
    output logic              timeout_o,

    output logic [ADDR_W-1:0] awaddr,
    output logic [2:0]        awprot,
    output logic              awvalid,
    input  logic              awready,

    output logic [DATA_W-1:0] wdata,
    output logic [STRB_W-1:0] wstrb,
    output logic              wvalid,
    input  logic              wready,

    input  logic [1:0]        bresp,
    input  logic              bvalid,
    output logic              bready,

    output logic [ADDR_W-1:0] araddr,
    output logic [2:0]        arprot,
    output logic              arvalid,
    input  logic              arready,

    input  logic [DATA_W-1:0] rdata,
    input  logic [1:0]        rresp,
    input  logic              rvalid,
    output logic              rready
);

    // state | meaning
    // IDLE  | cmd_ready high, waiting for a command
    // WR    | AW and/or W still pending
    // WB    | both write beats sent, waiting for B
    // RA    | AR pending
    // RD    | AR sent, waiting for R
    typedef enum logic [2:0] {IDLE, WR, WB, RA, RD} state_t;

    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    // The counter reads 0 in the first busy cycle, so TIMEOUT-2 marks the last cycle allowed.
    localparam logic [CNT_W-1:0] CNT_TC = CNT_W'((TIMEOUT >= 2) ? TIMEOUT - 2 : 0);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    if (DATA_W != 32 && DATA_W != 64) begin : g_bad_data_w
        $error("axil_master_v2: DATA_W must be 32 or 64");
    end

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [STRB_W-1:0]   wstrb_q, wstrb_d;
    logic                cmd_ready_q, cmd_ready_d;
    logic                awvalid_q, awvalid_d;
    logic                wvalid_q, wvalid_d;
    logic                bready_q, bready_d;
    logic                arvalid_q, arvalid_d;
    logic                rready_q, rready_d;
    logic                done_q, done_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic [1:0]          resp_q, resp_d;
    logic                err_q, err_d;
    logic                timeout_q, timeout_d;
    logic                timeout_hit;
    logic                complete;

    assign timeout_hit = (TIMEOUT != 0) && (cnt_q >= CNT_TC);

    always_comb begin
        state_d     = state_q;
        cnt_d       = (state_q == IDLE) ? '0 : cnt_q + CNT_W'(1);
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        awvalid_d   = awvalid_q;
        wvalid_d    = wvalid_q;
        bready_d    = bready_q;
        arvalid_d   = arvalid_q;
        rready_d    = rready_q;
        done_d      = 1'b0;
        rdata_d     = rdata_q;
        resp_d      = resp_q;
        timeout_d   = timeout_q;
        complete    = 1'b0;

        case (state_q)
            IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    addr_d  = cmd_addr;
                    wdata_d = cmd_wdata;
                    wstrb_d = cmd_wstrb;
                    if (cmd_we) begin
                        state_d   = WR;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                    end else begin
                        state_d   = RA;
                        arvalid_d = 1'b1;
                    end
                end
            end
            WR: begin
                if (awvalid_q && awready) awvalid_d = 1'b0;
                if (wvalid_q && wready)   wvalid_d  = 1'b0;
                if (!awvalid_d && !wvalid_d) begin
                    state_d  = WB;
                    bready_d = 1'b1;
                end
            end
            WB: begin
                if (bvalid) begin
                    state_d   = IDLE;
                    bready_d  = 1'b0;
                    complete  = 1'b1;
                    done_d    = 1'b1;
                    resp_d    = bresp;
                    timeout_d = 1'b0;
                end
            end
            RA: begin
                if (arready) begin
                    state_d   = RD;
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                end
            end
            RD: begin
                if (rvalid) begin
                    state_d   = IDLE;
                    rready_d  = 1'b0;
                    complete  = 1'b1;
                    done_d    = 1'b1;
                    rdata_d   = rdata;
                    resp_d    = rresp;
                    timeout_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        // A final B/R handshake in the expiry cycle still counts as a normal completion.
        if (state_q != IDLE && timeout_hit && !complete) begin
            state_d   = IDLE;
            awvalid_d = 1'b0;
            wvalid_d  = 1'b0;
            bready_d  = 1'b0;
            arvalid_d = 1'b0;
            rready_d  = 1'b0;
            done_d    = 1'b1;
            resp_d    = RESP_SLVERR;
            timeout_d = 1'b1;
        end

        cmd_ready_d = (state_d == IDLE);
        err_d       = (resp_d != RESP_OKAY);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            cmd_ready_q <= 1'b1;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            done_q      <= 1'b0;
            rdata_q     <= '0;
            resp_q      <= RESP_OKAY;
            err_q       <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            cmd_ready_q <= cmd_ready_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            bready_q    <= bready_d;
            arvalid_q   <= arvalid_d;
            rready_q    <= rready_d;
            done_q      <= done_d;
            rdata_q     <= rdata_d;
            resp_q      <= resp_d;
            err_q       <= err_d;
            timeout_q   <= timeout_d;
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign done_o    = done_q;
    assign rdata_o   = rdata_q;
    assign resp_o    = resp_q;
    assign err_o     = err_q;
    assign timeout_o = timeout_q;

    assign awaddr    = addr_q;
    assign awprot    = 3'b000;
    assign awvalid   = awvalid_q;
    assign wdata     = wdata_q;
    assign wstrb     = wstrb_q;
    assign wvalid    = wvalid_q;
    assign bready    = bready_q;
    assign araddr    = addr_q;
    assign arprot    = 3'b000;
    assign arvalid   = arvalid_q;
    assign rready    = rready_q;

endmodule

// File: tb/tb_axil_master_v2.sv
// Bench for axil_master_v2: a cycle-accurate slave driven from per-transaction latencies, checked
// against a transaction-level model of when each channel must be active and what done_o returns.
module tb_axil_master_v2;
    localparam int AW     = 32;
    localparam int DW     = 32;
    localparam int SW     = DW / 8;
    localparam int TO     = 8;
    localparam int LAST_K = TO - 1;   // last cycle after accept in which a handshake may still finish

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          cmd_valid, cmd_ready, cmd_we;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic [SW-1:0] cmd_wstrb;
    logic          done_o, err_o, timeout_o;
    logic [DW-1:0] rdata_o;
    logic [1:0]    resp_o;
    logic [AW-1:0] awaddr, araddr;
    logic [2:0]    awprot, arprot;
    logic          awvalid, awready, wvalid, wready, bvalid, bready;
    logic          arvalid, arready, rvalid, rready;
    logic [DW-1:0] wdata, rdata;
    logic [SW-1:0] wstrb;
    logic [1:0]    bresp, rresp;

    int checks   = 0;
    int failures = 0;

    // Held response as the model expects it
    logic [DW-1:0] m_rdata;
    logic [1:0]    m_resp;
    logic          m_tout;

    always #5 clk = ~clk;

    axil_master_v2 #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .done_o(done_o), .rdata_o(rdata_o), .resp_o(resp_o), .err_o(err_o), .timeout_o(timeout_o),
        .awaddr(awaddr), .awprot(awprot), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready)
    );

    // Issues one command at the current negedge and runs the slave until the done_o cycle.
    // da: cycles awvalid/arvalid waits for ready, dw: wvalid wait, dd: B/R delay after bready/rready.
    task automatic run_txn(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                           input logic [SW-1:0] ws, input int da, input int dw, input int dd,
                           input logic [DW-1:0] rd, input logic [1:0] rsp, output int done_k);
        int            first, comp, end_k;
        logic          aborted;
        logic [6:0]    exp_ctl, got_ctl;
        logic [DW+3:0] exp_rsp, got_rsp;
        first   = we ? 1 + ((da > dw) ? da : dw) : 1 + da;
        comp    = first + 1 + dd;
        aborted = (comp > LAST_K);
        end_k   = aborted ? LAST_K : comp;

        checks++;
        if (cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL cmd_ready_at_issue got=%b exp=1", cmd_ready);
        end
        cmd_valid = 1'b1; cmd_we = we; cmd_addr = addr; cmd_wdata = wd; cmd_wstrb = ws;
        @(posedge clk);
        for (int k = 1; k <= end_k + 1; k++) begin
            @(negedge clk);
            if (k == end_k + 1) begin
                if (aborted) begin
                    m_resp = 2'b10;
                    m_tout = 1'b1;
                end else begin
                    m_resp = rsp;
                    m_tout = 1'b0;
                    if (!we) m_rdata = rd;
                end
            end
            exp_ctl = {we && (k <= 1 + da) && (k <= end_k),
                       we && (k <= 1 + dw) && (k <= end_k),
                       we && (k > first) && (k <= end_k),
                       !we && (k <= 1 + da) && (k <= end_k),
                       !we && (k > first) && (k <= end_k),
                       k == end_k + 1,
                       k == end_k + 1};
            got_ctl = {awvalid, wvalid, bready, arvalid, rready, done_o, cmd_ready};
            checks++;
            if (got_ctl !== exp_ctl) begin
                failures++;
                $display("FAIL ctl k=%0d aw/w/b/ar/r/done/cmd_ready got=%b exp=%b", k, got_ctl, exp_ctl);
            end
            if (exp_ctl[6]) begin
                checks++;
                if (awaddr !== addr) begin
                    failures++;
                    $display("FAIL awaddr k=%0d got=%h exp=%h", k, awaddr, addr);
                end
            end
            if (exp_ctl[5]) begin
                checks++;
                if ({wdata, wstrb} !== {wd, ws}) begin
                    failures++;
                    $display("FAIL wdata_wstrb k=%0d got=%h/%h exp=%h/%h", k, wdata, wstrb, wd, ws);
                end
            end
            if (exp_ctl[3]) begin
                checks++;
                if (araddr !== addr) begin
                    failures++;
                    $display("FAIL araddr k=%0d got=%h exp=%h", k, araddr, addr);
                end
            end
            if (k == 1) begin
                checks++;
                if ({awprot, arprot} !== 6'b0) begin
                    failures++;
                    $display("FAIL prot got=%b exp=000000", {awprot, arprot});
                end
            end
            exp_rsp = {m_rdata, m_resp, m_resp != 2'b00, m_tout};
            got_rsp = {rdata_o, resp_o, err_o, timeout_o};
            checks++;
            if (got_rsp !== exp_rsp) begin
                failures++;
                $display("FAIL resp k=%0d rdata/resp/err/tout got=%h exp=%h", k, got_rsp, exp_rsp);
            end

            // Stimulus for cycle k: garbage commands while busy, slave handshakes per latency
            cmd_valid = (k <= end_k) ? 1'($urandom_range(0, 1)) : 1'b0;
            cmd_we    = 1'($urandom);
            cmd_addr  = $urandom;
            cmd_wdata = $urandom;
            cmd_wstrb = SW'($urandom);
            awready   = we && (k == 1 + da) && (k <= end_k);
            wready    = we && (k == 1 + dw) && (k <= end_k);
            arready   = !we && (k == 1 + da) && (k <= end_k);
            bvalid    = we && (k == comp) && (k <= end_k);
            rvalid    = !we && (k == comp) && (k <= end_k);
            bresp     = (k == comp) ? rsp : 2'($urandom);
            rresp     = (k == comp) ? rsp : 2'($urandom);
            rdata     = (k == comp) ? rd : $urandom;
        end
        done_k = end_k + 1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            checks++;
            if ({cmd_ready, done_o, rdata_o, resp_o, timeout_o} !== {1'b1, 1'b0, m_rdata, m_resp, m_tout}) begin
                failures++;
                $display("FAIL idle_hold cmd_ready=%b done=%b rdata=%h resp=%b tout=%b", cmd_ready, done_o, rdata_o, resp_o, timeout_o);
            end
        end
    endtask

    task automatic test_reset();
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if ({cmd_ready, done_o, awvalid, wvalid, bready, arvalid, rready, err_o, timeout_o, resp_o, rdata_o}
            !== {1'b1, 8'b0, 2'b00, {DW{1'b0}}}) begin
            failures++;
            $display("FAIL reset_values cmd_ready=%b done=%b valids=%b resp=%b rdata=%h", cmd_ready, done_o,
                     {awvalid, wvalid, bready, arvalid, rready}, resp_o, rdata_o);
        end
        @(negedge clk);
        rst = 1'b0;
        m_rdata = '0; m_resp = 2'b00; m_tout = 1'b0;
        idle(2);
    endtask

    task automatic test_zero_wait_write();
        int dk;
        run_txn(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, 0, 0, '0, 2'b00, dk);
        checks++;
        if ({dk[3:0], err_o, resp_o} !== {4'd3, 1'b0, 2'b00}) begin
            failures++;
            $display("FAIL zero_wait_write done_k=%0d err=%b resp=%b exp 3/0/00", dk, err_o, resp_o);
        end
        idle(1);
    endtask

    task automatic test_staggered_write();
        int dk;
        run_txn(1'b1, 32'h24, 32'hA5A5_0F0F, 4'b0011, 3, 0, 0, '0, 2'b00, dk);
        checks++;
        if (dk != 6) begin
            failures++;
            $display("FAIL staggered_write done_k got=%0d exp=6", dk);
        end
        idle(1);
    endtask

    task automatic test_read_error();
        int dk;
        run_txn(1'b0, 32'h40, 32'h0, 4'h0, 2, 0, 0, 32'h12345678, 2'b10, dk);
        checks++;
        if ({rdata_o, resp_o, err_o} !== {32'h12345678, 2'b10, 1'b1} || dk != 5) begin
            failures++;
            $display("FAIL read_error rdata=%h resp=%b err=%b done_k=%0d exp 12345678/10/1/5", rdata_o, resp_o, err_o, dk);
        end
        idle(1);
    endtask

    task automatic test_timeout();
        int dk;
        run_txn(1'b1, 32'h80, 32'h1111_2222, 4'hF, 100, 0, 0, '0, 2'b00, dk);
        checks++;
        if ({timeout_o, resp_o, err_o} !== {1'b1, 2'b10, 1'b1} || dk != TO) begin
            failures++;
            $display("FAIL timeout tout=%b resp=%b err=%b done_k=%0d exp 1/10/1/%0d", timeout_o, resp_o, err_o, dk, TO);
        end
        run_txn(1'b0, 32'h84, 32'h0, 4'h0, 0, 0, 0, 32'hCAFE_F00D, 2'b00, dk);
        checks++;
        if ({timeout_o, resp_o} !== 3'b000 || dk != 3) begin
            failures++;
            $display("FAIL after_timeout tout=%b resp=%b done_k=%0d exp 0/00/3", timeout_o, resp_o, dk);
        end
        idle(1);
    endtask

    // Completion in the final allowed cycle wins over the timeout; one cycle later it does not.
    task automatic test_timeout_boundary();
        int dk;
        run_txn(1'b1, 32'h90, 32'h5555_AAAA, 4'hC, 2, 2, 3, '0, 2'b01, dk);
        checks++;
        if ({timeout_o, resp_o} !== 3'b001 || dk != TO) begin
            failures++;
            $display("FAIL boundary_write tout=%b resp=%b done_k=%0d exp 0/01/%0d", timeout_o, resp_o, dk, TO);
        end
        run_txn(1'b0, 32'h94, 32'h0, 4'h0, 2, 0, 3, 32'h0BAD_BEEF, 2'b00, dk);
        run_txn(1'b0, 32'h98, 32'h0, 4'h0, 2, 0, 4, 32'h7777_7777, 2'b00, dk);
        checks++;
        if ({timeout_o, rdata_o} !== {1'b1, 32'h0BAD_BEEF}) begin
            failures++;
            $display("FAIL boundary_read tout=%b rdata=%h exp 1/0badbeef", timeout_o, rdata_o);
        end
        idle(1);
    endtask

    task automatic test_back_to_back();
        int dk;
        run_txn(1'b1, 32'hA0, 32'h0102_0304, 4'hF, 0, 0, 0, '0, 2'b11, dk);
        run_txn(1'b0, 32'hA4, 32'h0, 4'h0, 0, 0, 1, 32'h5A5A_A5A5, 2'b00, dk);
        checks++;
        if ({resp_o, err_o, rdata_o} !== {2'b00, 1'b0, 32'h5A5A_A5A5} || dk != 4) begin
            failures++;
            $display("FAIL back_to_back resp=%b err=%b rdata=%h done_k=%0d", resp_o, err_o, rdata_o, dk);
        end
        idle(1);
    endtask

    task automatic test_reset_mid_txn();
        int dk;
        cmd_valid = 1'b1; cmd_we = 1'b1; cmd_addr = 32'hB0; cmd_wdata = 32'hFEED_0001; cmd_wstrb = 4'hF;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0; awready = 1'b1; wready = 1'b1;
        @(negedge clk);
        awready = 1'b0; wready = 1'b0;
        checks++;
        if (bready !== 1'b1) begin
            failures++;
            $display("FAIL wb_entry bready got=%b exp=1", bready);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({awvalid, wvalid, bready, arvalid, rready, done_o, cmd_ready} !== 7'b0000001) begin
            failures++;
            $display("FAIL reset_mid_txn valids/done/cmd_ready got=%b exp=0000001",
                     {awvalid, wvalid, bready, arvalid, rready, done_o, cmd_ready});
        end
        @(negedge clk);
        rst = 1'b0;
        m_rdata = '0; m_resp = 2'b00; m_tout = 1'b0;
        idle(3);
        run_txn(1'b0, 32'hB4, 32'h0, 4'h0, 1, 0, 0, 32'h3C3C_C3C3, 2'b00, dk);
        idle(1);
    endtask

    task automatic test_random();
        int dk;
        for (int i = 0; i < 40; i++) begin
            logic          we;
            logic [AW-1:0] a;
            logic [DW-1:0] wd, rd;
            logic [SW-1:0] ws;
            logic [1:0]    rsp;
            int            da, dw, dd;
            we  = 1'($urandom);
            a   = $urandom;
            wd  = $urandom;
            rd  = $urandom;
            ws  = SW'($urandom);
            rsp = 2'($urandom);
            da  = int'($urandom_range(0, 3));
            dw  = int'($urandom_range(0, 3));
            dd  = int'($urandom_range(0, 3));
            run_txn(we, a, wd, ws, da, dw, dd, rd, rsp, dk);
            idle(int'($urandom_range(0, 2)));
        end
    endtask

    initial begin
        cmd_valid = 1'b0; cmd_we = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
        arready = 1'b0; rvalid = 1'b0; rresp = 2'b00; rdata = '0;
        m_rdata = '0; m_resp = 2'b00; m_tout = 1'b0;
        test_reset();
        test_zero_wait_write();
        test_staggered_write();
        test_read_error();
        test_timeout();
        test_timeout_boundary();
        test_back_to_back();
        test_reset_mid_txn();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end

endmodule
